// File: rtl/load_store_unit_pkg.sv
// Opcodes, FSM states and access-size decode shared by the load/store unit and its lane aligner.
package load_store_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  // SZ_NONE marks an opcode the unit does not support.
  function automatic size_e op_size(input logic [5:0] op);
    size_e sz;
    sz = SZ_NONE;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LW, OP_SW:         sz = SZ_WORD;
      default:              sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_sext(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic op_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_reject(input logic [5:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op_size(op))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts and extends load data, merges sub-word store data into a word.
module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [5:0]  i_op,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [1:0]  w_blane;
  logic        w_hlane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    // Physical lane index counted from bit 0 upward.
    w_blane = BIG_ENDIAN ? (2'd3 - i_offset) : i_offset;
    w_hlane = BIG_ENDIAN ? ~i_offset[1] : i_offset[1];
    w_byte  = i_word[{w_blane, 3'b000} +: 8];
    w_half  = i_word[{w_hlane, 4'b0000} +: 16];
    w_sext  = op_sext(i_op);
    o_load  = i_word;
    o_store = i_word;
    case (op_size(i_op))
      SZ_BYTE: begin
        o_load = {{24{w_sext & w_byte[7]}}, w_byte};
        o_store[{w_blane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{w_sext & w_half[15]}}, w_half};
        o_store[{w_hlane, 4'b0000} +: 16] = i_wdata[15:0];
      end
      SZ_WORD: begin
        o_load  = i_word;
        o_store = i_wdata;
      end
      default: begin
        o_load  = i_word;
        o_store = i_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic [5:0]        i_op,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_din,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  input  logic [31:0]       i_mem_dout
);

  state_e            r_state;
  logic [5:0]        r_op;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [31:0]       r_rdata;

  logic [31:0]       w_word;
  logic [31:0]       w_load;
  logic [31:0]       w_store;
  logic              w_unused_addr;

  // Upper address bits wrap and are deliberately dropped.
  assign w_unused_addr = ^i_addr[31:ADDR_W+2];

  // Loads extract straight from memory during RD; store merges use the buffered word.
  assign w_word = (r_state == S_RD) ? i_mem_dout : r_buf;

  load_store_unit_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .i_word  (w_word),
    .i_offset(r_addr[1:0]),
    .i_op    (r_op),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_store (w_store)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_op    <= i_op;
            r_addr  <= i_addr[ADDR_W+1:0];
            r_wdata <= i_wdata;
            if (op_reject(i_op, i_addr[1:0])) begin
              r_state <= S_ERR;
            end else if (i_op == OP_SW) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_buf <= i_mem_dout;
          if (op_store(r_op)) begin
            r_state <= S_WR;
          end else begin
            r_rdata <= w_load;
            r_state <= S_DONE;
          end
        end
        S_WR:          r_state <= S_DONE;
        S_DONE, S_ERR: r_state <= S_IDLE;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an asynchronous reset removes them immediately.
  assign o_rdata    = r_rdata;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE) || (r_state == S_ERR);
  assign o_err      = (r_state == S_ERR);
  assign o_mem_ren  = (r_state == S_RD);
  assign o_mem_wen  = (r_state == S_WR);
  assign o_mem_addr = r_addr[ADDR_W+1:2];
  assign o_mem_din  = w_store;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: big-endian and little-endian instances, each with a word memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  logic        req_be, req_le;
  logic [5:0]  op;
  logic [31:0] addr, wdata;

  logic [31:0] rdata_be, din_be, dout_be;
  logic [31:0] rdata_le, din_le, dout_le;
  logic        busy_be, done_be, err_be, ren_be, wen_be;
  logic        busy_le, done_le, err_le, ren_le, wen_le;
  logic [9:0]  maddr_be, maddr_le;

  logic [31:0] mem_be [1024];
  logic [31:0] mem_le [1024];

  int total = 0;
  int bad   = 0;

  load_store_unit #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) dut_be (
    .i_clk(clk), .i_reset(rst), .i_req(req_be), .i_op(op), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata_be), .o_busy(busy_be), .o_done(done_be), .o_err(err_be),
    .o_mem_addr(maddr_be), .o_mem_din(din_be), .o_mem_ren(ren_be), .o_mem_wen(wen_be),
    .i_mem_dout(dout_be)
  );

  load_store_unit #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) dut_le (
    .i_clk(clk), .i_reset(rst), .i_req(req_le), .i_op(op), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata_le), .o_busy(busy_le), .o_done(done_le), .o_err(err_le),
    .o_mem_addr(maddr_le), .o_mem_din(din_le), .o_mem_ren(ren_le), .o_mem_wen(wen_le),
    .i_mem_dout(dout_le)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem_be[i] <= '0;
        mem_le[i] <= '0;
      end
    end else begin
      if (wen_be) mem_be[maddr_be] <= din_be;
      if (wen_le) mem_le[maddr_le] <= din_le;
    end
  end

  assign dout_be = mem_be[maddr_be];
  assign dout_le = mem_le[maddr_le];

  // Issues one request and watches it to completion; lat stays -1 if done never arrives.
  task automatic run_op(input bit le, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int nren, output int nwen,
                        output logic [31:0] din, output logic [9:0] maddr, output logic e);
    lat = -1; nren = 0; nwen = 0; din = '0; maddr = '0; e = 1'b0;
    @(negedge clk);
    op = o; addr = a; wdata = d;
    if (le) req_le = 1'b1; else req_be = 1'b1;
    @(posedge clk);
    #1;
    req_le = 1'b0; req_be = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (le ? ren_le : ren_be) begin
        nren++;
        maddr = le ? maddr_le : maddr_be;
      end
      if (le ? wen_le : wen_be) begin
        nwen++;
        din   = le ? din_le : din_be;
        maddr = le ? maddr_le : maddr_be;
      end
      if (le ? done_le : done_be) begin
        lat = c;
        e   = le ? err_le : err_be;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b1; req_be = 1'b0; req_le = 1'b0; op = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0;
    @(negedge clk);
    total++; if (rdata_be !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", rdata_be, 32'h0); end
    total++; if (busy_be !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_be); end
    total++; if (done_be !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_be); end
    total++; if (err_be !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_be); end
    total++; if ({ren_be, wen_be} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {ren_be, wen_be}); end
    total++; if (maddr_be !== 10'd0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", maddr_be); end
    total++; if (din_be !== 32'h0) begin bad++; $display("FAIL reset_mem_din got=%h want=0", din_be); end
  endtask

  task automatic test_word;
    int lat, nr, nw; logic [31:0] din; logic [9:0] ma; logic e;
    run_op(1'b0, 6'h2B, 32'h3C, 32'hCAFEBABE, lat, nr, nw, din, ma, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    total++; if (nw !== 1 || nr !== 0) begin bad++; $display("FAIL sw_strobes got wen=%0d ren=%0d want wen=1 ren=0", nw, nr); end
    total++; if (ma !== 10'd15) begin bad++; $display("FAIL sw_mem_addr got=%0d want=15", ma); end
    total++; if (din !== 32'hCAFEBABE) begin bad++; $display("FAIL sw_mem_din got=%h want=cafebabe", din); end
    run_op(1'b0, 6'h23, 32'h3C, 32'h0, lat, nr, nw, din, ma, e);
    total++; if (rdata_be !== 32'hCAFEBABE) begin bad++; $display("FAIL lw_rdata got=%h want=cafebabe", rdata_be); end
    total++; if (lat !== 2 || e !== 1'b0) begin bad++; $display("FAIL lw_done got lat=%0d err=%b want lat=2 err=0", lat, e); end
    total++; if (nr !== 1 || nw !== 0 || ma !== 10'd15) begin bad++; $display("FAIL lw_strobes got ren=%0d wen=%0d addr=%0d want 1 0 15", nr, nw, ma); end
  endtask

  task automatic test_byte_rmw;
    int lat, nr, nw; logic [31:0] din; logic [9:0] ma; logic e;
    run_op(1'b0, 6'h28, 32'h3D, 32'h000000A5, lat, nr, nw, din, ma, e);
    total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d want=3", lat); end
    total++; if (nr !== 1 || nw !== 1) begin bad++; $display("FAIL sb_strobes got ren=%0d wen=%0d want 1 1", nr, nw); end
    total++; if (din !== 32'hCAA5BABE) begin bad++; $display("FAIL sb_mem_din got=%h want=caa5babe", din); end
    total++; if (mem_be[15] !== 32'hCAA5BABE) begin bad++; $display("FAIL sb_mem_word got=%h want=caa5babe", mem_be[15]); end
  endtask

  task automatic test_extension;
    logic [5:0]  t_op  [4];
    logic [31:0] t_adr [4];
    logic [31:0] t_exp [4];
    int lat, nr, nw; logic [31:0] din; logic [9:0] ma; logic e;
    t_op  = '{6'h20, 6'h24, 6'h21, 6'h25};
    t_adr = '{32'h3D, 32'h3D, 32'h3E, 32'h3E};
    t_exp = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFBABE, 32'h0000BABE};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, t_op[i], t_adr[i], 32'h0, lat, nr, nw, din, ma, e);
      total++;
      if (rdata_be !== t_exp[i] || lat !== 2) begin
        bad++;
        $display("FAIL ext_load_%0d op=%h got=%h lat=%0d want=%h lat=2", i, t_op[i], rdata_be, lat, t_exp[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [5:0]  t_op  [3];
    logic [31:0] t_adr [3];
    int lat, nr, nw; logic [31:0] din; logic [9:0] ma; logic e;
    t_op  = '{6'h23, 6'h29, 6'h22};
    t_adr = '{32'h3E, 32'h3D, 32'h3C};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, t_op[i], t_adr[i], 32'h5555, lat, nr, nw, din, ma, e);
      total++; if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL err_%0d_pulse got lat=%0d err=%b want lat=1 err=1", i, lat, e); end
      total++; if (nr !== 0 || nw !== 0) begin bad++; $display("FAIL err_%0d_strobes got ren=%0d wen=%0d want 0 0", i, nr, nw); end
      total++; if (rdata_be !== 32'h0000BABE) begin bad++; $display("FAIL err_%0d_rdata got=%h want=0000babe", i, rdata_be); end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, nr, nw; logic [31:0] din; logic [9:0] ma; logic e;
    run_op(1'b0, 6'h2B, 32'h40, 32'h11112222, lat, nr, nw, din, ma, e);
    @(negedge clk);
    op = 6'h29; addr = 32'h40; wdata = 32'h1234; req_be = 1'b1;
    @(posedge clk);
    #1 req_be = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (wen_be !== 1'b1) begin bad++; $display("FAIL rstwr_in_wr got wen=%b want=1", wen_be); end
    rst = 1'b1;
    #1;
    total++; if (wen_be !== 1'b0) begin bad++; $display("FAIL rstwr_wen_drop got=%b want=0", wen_be); end
    total++; if (busy_be !== 1'b0 || done_be !== 1'b0) begin bad++; $display("FAIL rstwr_idle got busy=%b done=%b want 0 0", busy_be, done_be); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 6'h23, 32'h40, 32'h0, lat, nr, nw, din, ma, e);
    total++; if (rdata_be !== 32'h11112222) begin bad++; $display("FAIL rstwr_preserved got=%h want=11112222", rdata_be); end
  endtask

  task automatic test_back_to_back;
    int ndone, nwen;
    logic [9:0] mask;
    ndone = 0; nwen = 0; mask = '0;
    @(negedge clk);
    op = 6'h2B; addr = 32'h0; wdata = 32'h0A0A0A0A; req_be = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (wen_be) nwen++;
      if (done_be) begin
        ndone++;
        mask[c] = 1'b1;
        addr  = addr ^ 32'h4;
        wdata = (ndone == 1) ? 32'h0B0B0B0B : 32'h0C0C0C0C;
      end
      if (c == 9) req_be = 1'b0;
    end
    total++; if (mask !== 10'h124) begin bad++; $display("FAIL b2b_done_cycles got=%h want=124", mask); end
    total++; if (nwen !== 3) begin bad++; $display("FAIL b2b_writes got=%0d want=3", nwen); end
    total++; if (mem_be[0] !== 32'h0C0C0C0C || mem_be[1] !== 32'h0B0B0B0B) begin
      bad++; $display("FAIL b2b_data got=%h,%h want=0c0c0c0c,0b0b0b0b", mem_be[0], mem_be[1]);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone, lat;
    ndone = 0; lat = -1;
    @(negedge clk);
    op = 6'h28; addr = 32'h3C; wdata = 32'h77; req_be = 1'b1;
    @(posedge clk);
    #1;
    op = 6'h2B; addr = 32'h8; wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done_be) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (c == 4) req_be = 1'b0;
    end
    total++; if (ndone !== 1 || lat !== 3) begin bad++; $display("FAIL busy_done got count=%0d lat=%0d want 1 3", ndone, lat); end
    total++; if (mem_be[2] !== 32'h0) begin bad++; $display("FAIL busy_no_write got=%h want=0", mem_be[2]); end
    total++; if (mem_be[15] !== 32'h77A5BABE) begin bad++; $display("FAIL busy_sb_word got=%h want=77a5babe", mem_be[15]); end
  endtask

  task automatic test_little_endian;
    int lat, nr, nw; logic [31:0] din; logic [9:0] ma; logic e;
    run_op(1'b1, 6'h2B, 32'h3C, 32'hCAFEBABE, lat, nr, nw, din, ma, e);
    total++; if (lat !== 2 || din !== 32'hCAFEBABE) begin bad++; $display("FAIL le_sw got lat=%0d din=%h want 2 cafebabe", lat, din); end
    run_op(1'b1, 6'h28, 32'h3D, 32'h000000A5, lat, nr, nw, din, ma, e);
    total++; if (din !== 32'hCAFEA5BE || lat !== 3) begin bad++; $display("FAIL le_sb got din=%h lat=%0d want cafea5be 3", din, lat); end
    run_op(1'b1, 6'h20, 32'h3D, 32'h0, lat, nr, nw, din, ma, e);
    total++; if (rdata_le !== 32'hFFFFFFA5) begin bad++; $display("FAIL le_lb got=%h want=ffffffa5", rdata_le); end
    run_op(1'b1, 6'h25, 32'h3E, 32'h0, lat, nr, nw, din, ma, e);
    total++; if (rdata_le !== 32'h0000CAFE) begin bad++; $display("FAIL le_lhu got=%h want=0000cafe", rdata_le); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_rmw();
    test_extension();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    test_busy_ignore();
    test_little_endian();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts MIPS load/store requests from the MEM stage and drives the word-only data memory.
- The memory has a 10-bit word address, 32-bit din/dout, ren/wen, and a posedge write.
- Adds byte/halfword access: loads are extracted and sign- or zero-extended; sb/sh use read-modify-write because memory writes whole words only.
- Checks alignment and signals completion with a done/err pulse.

Parameters:
- ADDR_W, 10: memory word-address width; mem_addr = addr[ADDR_W+1:2].
- BIG_ENDIAN, 1: 1 = byte offset 0 is bits [31:24] (MIPS default); 0 = byte offset 0 is bits [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, async active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- op  in  6  MIPS opcode: lb=6'h20, lh=6'h21, lw=6'h23, lbu=6'h24, lhu=6'h25, sb=6'h28, sh=6'h29, sw=6'h2B.
- addr  in  32  byte address; bits above ADDR_W+1 are ignored (wrap).
- wdata  in  32  store data; sb uses [7:0], sh uses [15:0].
- rdata  out  32  extended load result; registered; held until the next load completes.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done; misaligned or unsupported op.
- mem_addr  out  ADDR_W  word address to memory.
- mem_din  out  32  write word to memory.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_dout  in  32  memory read data; valid in the same cycle as mem_ren with stable mem_addr.

Behaviour:
- Reset: state=IDLE; rdata=0, done=0, err=0, busy=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0. Reset is effective immediately, mid-operation included; mem_wen drops combinationally so no partial write occurs.
- Request capture: on acceptance, op, addr and wdata are registered. mem_addr and mem_din come from the registered copies, so they are stable throughout an access.
- Memory strobes: Moore-decoded from the registered state. mem_ren=1 only in RD; mem_wen=1 only in WR.
- State IDLE: if req=1, latch the request, then:
  - misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) or unsupported op -> ERR;
  - lw/lh/lhu/lb/lbu/sb/sh -> RD;
  - sw -> WR.
- State RD: mem_ren=1. At the clock edge, capture mem_dout into a word buffer. Loads go to DONE and rdata is written on that same edge. sb/sh go to WR.
- State WR: mem_wen=1. Data written:
  - sw: mem_din = wdata.
  - sb/sh: mem_din = buffer with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0].
  - Next state is DONE.
- State DONE: done=1 for one cycle, then IDLE.
- State ERR: done=1 and err=1 for one cycle, then IDLE. No memory strobe is issued and rdata is unchanged.
- Lane select (BIG_ENDIAN=1):
  - byte offset k -> bits [31-8k -: 8];
  - halfword offset 0 -> [31:16], offset 2 -> [15:0].
- Load extension: lb/lh sign-extend; lbu/lhu zero-extend.
- Latency from accept edge to done: lw/lb/lbu/lh/lhu = 2 cycles; sw = 2; sb/sh = 3; error = 1.
- req while busy is ignored and not queued. With req held high continuously, a new request is accepted on the cycle after done.
- No timeout; the memory is assumed zero-wait.

Decomposition:
- Shared include lsu_defs.vh:
  - opcode localparams (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW);
  - state encoding (S_IDLE, S_RD, S_WR, S_DONE, S_ERR);
  - size/extension field decode constants.
- Sub-module lsu_align, purely combinational:
  - inputs: word, offset, op, wdata, BIG_ENDIAN;
  - outputs: extended load value and merged store word.
- The top level holds only the FSM and registers.

Test Plan:
- Full-word store/load: memory cleared by reset; sw addr=0x3C wdata=0xCAFEBABE -> exactly one mem_wen cycle, mem_addr=15, mem_din=0xCAFEBABE, done 2 cycles after accept. Then lw 0x3C -> rdata=0xCAFEBABE, err=0.
- Byte read-modify-write: sb addr=0x3D wdata=0x000000A5 on a word holding 0xCAFEBABE -> RD cycle then WR cycle with mem_din=0xCAA5BABE, done 3 cycles after accept.
- Load extension on word 0xCAA5BABE:
  - lb 0x3D -> 0xFFFFFFA5;
  - lbu 0x3D -> 0x000000A5;
  - lh 0x3E -> 0xFFFFBABE;
  - lhu 0x3E -> 0x0000BABE.
- Errors: lw 0x3E, sh 0x3D and op=6'h22 each -> done=1 and err=1 one cycle after accept; mem_ren=mem_wen=0 throughout; rdata unchanged.
- Reset during WR of sh addr=0x40 wdata=0x1234 -> mem_wen falls in the same delta; busy=0; a later lw 0x40 returns the pre-store value.
- req held high with alternating sw addr=0x0/0x4 -> accept, WR, DONE, accept, ... (one access per 3 cycles); req pulses during busy produce no extra done.
- BIG_ENDIAN=0: sb 0x3D wdata=0xA5 on 0xCAFEBABE -> mem_din=0xCAFEA5BE.
